ddr3_axi_mport_arb: RTL and testbench

//  Multi-port request front-end for the DDR3 controller: arbitrates NUM_PORTS AXI-derived

---
 rtl/ddr3_axi_mport_arb.sv | 91 +++++++++
 tb/tb_ddr3_axi_mport_arb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ddr3_axi_mport_arb.sv
// ddr3_axi_mport_arb: arbitrates NUM_PORTS AXI request channels onto the single ddr3_fsm
// command interface and splits each AXI burst into BURST_BEATS-beat commands tagged {port, id}.
// Ports: clock/reset (async, active-high); req_valid_i/req_ready_o/req_write_i/req_addr_i/
// req_id_i/req_len_i per-port request channels (packed, port p at slice p); mem_req_o/mem_ack_i
// command handshake with mem_wr_o/mem_last_o/mem_adr_o/mem_tid_o fields; busy_o while issuing.
module ddr3_axi_mport_arb #(
    parameter int NUM_PORTS    = 4,
    parameter int ADDR_BITS    = 25,
    parameter int AXI_ID_WIDTH = 4,
    parameter int BURST_BEATS  = 4,
    parameter int ARB_MODE     = 0,
    parameter int AGE_LIMIT    = 15,
    localparam int PB          = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
    localparam int TID         = PB + AXI_ID_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              req_valid_i,
    output logic [NUM_PORTS-1:0]              req_ready_o,
    input  logic [NUM_PORTS-1:0]              req_write_i,
    input  logic [NUM_PORTS*ADDR_BITS-1:0]    req_addr_i,
    input  logic [NUM_PORTS*AXI_ID_WIDTH-1:0] req_id_i,
    input  logic [NUM_PORTS*8-1:0]            req_len_i,
    output logic                              mem_req_o,
    input  logic                              mem_ack_i,
    output logic                              mem_wr_o,
    output logic                              mem_last_o,
    output logic [ADDR_BITS-1:0]              mem_adr_o,
    output logic [TID-1:0]                    mem_tid_o,
    output logic                              busy_o
);
    localparam int SH = $clog2(BURST_BEATS);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state;
    logic [PB-1:0] ptr, g, g_rr, g_pr;
    logic [7:0] age [NUM_PORTS];
    logic [7:0] cnt, len_g;
    // Round-robin searches from ptr; priority takes the lowest valid index, overridden by the
    // lowest aged index. Loops run high-to-low so the lowest candidate is assigned last.
    always_comb begin
        g_rr = '0;
        g_pr = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_valid_i[(int'(ptr) + i) % NUM_PORTS]) g_rr = PB'((int'(ptr) + i) % NUM_PORTS);
            if (req_valid_i[i]) g_pr = PB'(i);
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (req_valid_i[i] && age[i] >= 8'(AGE_LIMIT)) g_pr = PB'(i);
    end
    assign g           = (ARB_MODE == 1) ? g_pr : g_rr;
    assign len_g       = req_len_i[g*8 +: 8];
    // Accept is combinational in IDLE and forced low while reset is held.
    assign req_ready_o = (!reset && state == IDLE && |req_valid_i) ? NUM_PORTS'(1) << g : '0;
    assign mem_req_o   = state == ISSUE;
    assign busy_o      = state == ISSUE;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            mem_wr_o   <= 1'b0;
            mem_last_o <= 1'b0;
            mem_adr_o  <= '0;
            mem_tid_o  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) age[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++)
                age[p] <= (!req_valid_i[p] || req_ready_o[p]) ? 8'd0 : (age[p] == 8'hFF) ? age[p] : age[p] + 8'd1;
            if (state == IDLE) begin
                if (|req_valid_i) begin
                    state      <= ISSUE;
                    ptr        <= PB'((int'(g) + 1) % NUM_PORTS);
                    mem_wr_o   <= req_write_i[g];
                    mem_adr_o  <= req_addr_i[g*ADDR_BITS +: ADDR_BITS];
                    mem_tid_o  <= {g, req_id_i[g*AXI_ID_WIDTH +: AXI_ID_WIDTH]};
                    cnt        <= len_g >> SH;
                    mem_last_o <= (len_g >> SH) == 8'd0;
                end
            end else if (mem_ack_i) begin
                if (cnt == 8'd0) begin
                    state      <= IDLE;
                    mem_last_o <= 1'b0;
                end else begin
                    cnt        <= cnt - 8'd1;
                    mem_adr_o  <= mem_adr_o + ADDR_BITS'(BURST_BEATS);
                    mem_last_o <= cnt == 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr3_axi_mport_arb.sv
// tb_ddr3_axi_mport_arb: directed checks of arbitration, burst splitting, wrap, stall and reset
module tb_ddr3_axi_mport_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] wr_all = '0;
    logic [99:0] addr_all = '0;
    logic [15:0] id_all = {4'hD, 4'hC, 4'hB, 4'hA};
    logic [31:0] len_all = '0;
    logic [3:0] v0 = '0, v1 = '0, v2 = '0, r0, r1, r2;
    logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0;
    logic q0, q1, q2, w0, w1, w2, l0, l1, l2, b0, b1, b2;
    logic [24:0] ad0, ad1, ad2;
    logic [5:0] t0, t1, t2;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    ddr3_axi_mport_arb d0 (.clock(clk), .reset(reset), .req_valid_i(v0), .req_ready_o(r0),
        .req_write_i(wr_all), .req_addr_i(addr_all), .req_id_i(id_all), .req_len_i(len_all),
        .mem_req_o(q0), .mem_ack_i(a0), .mem_wr_o(w0), .mem_last_o(l0), .mem_adr_o(ad0),
        .mem_tid_o(t0), .busy_o(b0));
    ddr3_axi_mport_arb #(.ARB_MODE(1), .AGE_LIMIT(3)) d1 (.clock(clk), .reset(reset),
        .req_valid_i(v1), .req_ready_o(r1), .req_write_i(wr_all), .req_addr_i(addr_all),
        .req_id_i(id_all), .req_len_i(len_all), .mem_req_o(q1), .mem_ack_i(a1), .mem_wr_o(w1),
        .mem_last_o(l1), .mem_adr_o(ad1), .mem_tid_o(t1), .busy_o(b1));
    ddr3_axi_mport_arb #(.BURST_BEATS(16)) d2 (.clock(clk), .reset(reset), .req_valid_i(v2),
        .req_ready_o(r2), .req_write_i(wr_all), .req_addr_i(addr_all), .req_id_i(id_all),
        .req_len_i(len_all), .mem_req_o(q2), .mem_ack_i(a2), .mem_wr_o(w2), .mem_last_o(l2),
        .mem_adr_o(ad2), .mem_tid_o(t2), .busy_o(b2));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_all(input logic [24:0] adr, input logic [7:0] len, input logic wr);
        for (int p = 0; p < 4; p++) begin
            addr_all[p*25 +: 25] = adr;
            len_all[p*8 +: 8] = len;
            wr_all[p] = wr;
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask
    initial begin
        step();
        step();
        chk("rst_req", q0, 0);
        chk("rst_busy", b0, 0);
        chk("rst_adr", ad0, 0);
        chk("rst_tid", t0, 0);
        chk("rst_last", l0 | w0, 0);
        reset = 1'b0;
        #1;
        set_all(25'h100, 8'd7, 1'b0);
        a0 = 1'b1;
        v0 = 4'b0001;
        #1;
        chk("t1_ready", r0, 4'b0001);
        step();
        v0 = 4'b0000;
        chk("t1_req0", q0, 1);
        chk("t1_adr0", ad0, 25'h100);
        chk("t1_last0", l0, 0);
        chk("t1_tid", t0, 6'h0A);
        chk("t1_wr", w0, 0);
        chk("t1_busy", b0, 1);
        step();
        chk("t1_req1", q0, 1);
        chk("t1_adr1", ad0, 25'h104);
        chk("t1_last1", l0, 1);
        step();
        chk("t1_done", q0, 0);
        chk("t1_idle", b0, 0);
        do_reset();
        set_all(25'h300, 8'd0, 1'b0);
        a0 = 1'b1;
        v0 = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            for (int n = 0; n < 8 && r0 == 4'b0; n++) step();
            chk("rr_grant", r0, 32'd1 << (k % 4));
            step();
            chk("rr_pulse", r0, 0);
            chk("rr_tid", t0, ((k % 4) << 4) | (10 + k % 4));
        end
        v0 = 4'b0;
        step();
        step();
        chk("rr_quiet", q0, 0);
        do_reset();
        set_all(25'h300, 8'd0, 1'b0);
        a1 = 1'b1;
        v1 = 4'b0101;
        #1;
        chk("pr_g0a", r1, 4'b0001);
        step();
        step();
        chk("pr_g0b", r1, 4'b0001);
        step();
        chk("pr_issue", r1, 0);
        step();
        chk("pr_aged", r1, 4'b0100);
        step();
        chk("pr_tid", t1, 6'h2C);
        v1 = 4'b0;
        step();
        set_all(25'h1FFFFFE, 8'd7, 1'b1);
        a0 = 1'b0;
        v0 = 4'b0010;
        #1;
        chk("wr_ready", r0, 4'b0010);
        step();
        v0 = 4'b0;
        for (int k = 0; k < 5; k++) begin
            chk("st_req", q0, 1);
            chk("st_adr", ad0, 25'h1FFFFFE);
            chk("st_tid", t0, 6'h1B);
            chk("st_wr", w0, 1);
            chk("st_last", l0, 0);
            step();
        end
        a0 = 1'b1;
        step();
        chk("wrap_adr", ad0, 25'h0000002);
        chk("wrap_last", l0, 1);
        chk("wrap_req", q0, 1);
        step();
        chk("wrap_done", q0, 0);
        set_all(25'h200, 8'd11, 1'b0);
        v0 = 4'b0100;
        #1;
        chk("mr_ready", r0, 4'b0100);
        step();
        v0 = 4'b0;
        chk("mr_tid", t0, 6'h2C);
        chk("mr_adr0", ad0, 25'h200);
        step();
        chk("mr_adr1", ad0, 25'h204);
        reset = 1'b1;
        v0 = 4'hF;
        #1;
        chk("mr_req", q0, 0);
        chk("mr_busy", b0, 0);
        chk("mr_adr", ad0, 0);
        chk("mr_tid0", t0, 0);
        chk("mr_last", l0, 0);
        chk("mr_ready_rst", r0, 0);
        step();
        reset = 1'b0;
        #1;
        chk("mr_ptr0", r0, 4'b0001);
        step();
        chk("mr_next_tid", t0, 6'h0A);
        v0 = 4'b0;
        for (int n = 0; n < 6; n++) step();
        chk("mr_settle", q0, 0);
        set_all(25'h40, 8'd255, 1'b0);
        a2 = 1'b1;
        v2 = 4'b0001;
        #1;
        chk("b16_ready", r2, 4'b0001);
        step();
        v2 = 4'b0;
        for (int k = 0; k < 16; k++) begin
            chk("b16_req", q2, 1);
            chk("b16_adr", ad2, 25'h40 + 25'(k * 16));
            chk("b16_last", l2, (k == 15) ? 1 : 0);
            step();
        end
        chk("b16_done", q2, 0);
        chk("b16_busy", b2, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
